// File: rtl/vadd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vadd_ctrl_pkg
// Shared types and constants for the vadd kernel control sequencer.
//   ctrl_state_t          : sequencer FSM state encoding
//   DEFAULT_XFER_BYTES_C  : transfer size used when the host passes 0
//   BYTES_PER_BEAT_C      : m_axi beat size in bytes (transfer-size granule)
// ---------------------------------------------------------------------------
package vadd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } ctrl_state_t;

    localparam int unsigned DEFAULT_XFER_BYTES_C = 16384;
    localparam int unsigned BYTES_PER_BEAT_C     = 64;

endpackage : vadd_ctrl_pkg

// File: rtl/vadd_done_collector.sv
// ---------------------------------------------------------------------------
// vadd_done_collector
// Collects the per-engine done pulses of one run and keeps the run-cycle
// counter that also feeds the watchdog.
// Ports:
//   clk_i       in   kernel clock
//   rst_i       in   asynchronous reset, active-high
//   clear_i     in   start of a new run: drop sticky bits, zero the counter
//   run_i       in   high while the sequencer is in RUN
//   eng_done_i  in   per-engine 1-cycle done pulse
//   all_done_o  out  every engine has finished (includes this cycle's pulses)
//   cnt_inc_o   out  saturated counter+1 (cycle number of the current RUN cycle)
// ---------------------------------------------------------------------------
module vadd_done_collector
    import vadd_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 2,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   run_i,
    input  logic [NUM_ENGINES-1:0] eng_done_i,
    output logic                   all_done_o,
    output logic [CNT_WIDTH-1:0]   cnt_inc_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_ENGINES-1:0] seen;
    logic [CNT_WIDTH-1:0]   cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
            logic sticky_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sticky_q <= 1'b0;
                end else if (clear_i) begin
                    sticky_q <= 1'b0;
                end else if (run_i && eng_done_i[gi]) begin
                    sticky_q <= 1'b1;
                end
            end

            // Pulse arriving this cycle counts too, so the final done
            // does not have to wait a cycle to be registered first.
            assign seen[gi] = sticky_q | eng_done_i[gi];
        end
    endgenerate

    assign all_done_o = run_i & (&seen);

    // Saturate instead of wrapping so a very long run never looks short.
    assign cnt_inc_o = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_WIDTH'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= cnt_inc_o;
        end
    end

endmodule : vadd_done_collector

// File: rtl/vadd_kernel_ctrl_seq.sv
// ---------------------------------------------------------------------------
// vadd_kernel_ctrl_seq
// Kernel-level control sequencer for the vadd engines. Speaks ap_ctrl_chain
// to the host shell, latches and sanitises the transfer size, launches all
// engines together, waits for every done pulse and guards the run with a
// cycle watchdog.
// Ports:
//   ap_clk / areset        clock, asynchronous active-high reset
//   ap_start / ap_continue host start level and ap_done acknowledge
//   ap_idle / ap_ready / ap_done  handshake outputs (all registered)
//   scalar00               requested transfer size in bytes
//   timeout_cycles         watchdog limit in RUN cycles, 0 disables it
//   eng_start              per-engine 1-cycle start pulse
//   eng_xfer_bytes         sanitised transfer size for all engines
//   eng_done               per-engine 1-cycle done pulse
//   timeout_err            sticky: last run was ended by the watchdog
//   run_cycles             RUN cycles of the last completed run
// ---------------------------------------------------------------------------
module vadd_kernel_ctrl_seq
    import vadd_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ENGINES        = 2,
    parameter int unsigned XFER_SIZE_WIDTH    = 32,
    parameter int unsigned DEFAULT_XFER_BYTES = DEFAULT_XFER_BYTES_C,
    parameter int unsigned BYTES_PER_BEAT     = BYTES_PER_BEAT_C,
    parameter int unsigned CNT_WIDTH          = 32
) (
    input  logic                       ap_clk,
    input  logic                       areset,
    input  logic                       ap_start,
    input  logic                       ap_continue,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [XFER_SIZE_WIDTH-1:0] scalar00,
    input  logic [CNT_WIDTH-1:0]       timeout_cycles,
    output logic [NUM_ENGINES-1:0]     eng_start,
    output logic [XFER_SIZE_WIDTH-1:0] eng_xfer_bytes,
    input  logic [NUM_ENGINES-1:0]     eng_done,
    output logic                       timeout_err,
    output logic [CNT_WIDTH-1:0]       run_cycles
);

    localparam logic [XFER_SIZE_WIDTH-1:0] DEFAULT_BYTES = XFER_SIZE_WIDTH'(DEFAULT_XFER_BYTES);
    localparam logic [XFER_SIZE_WIDTH-1:0] BEAT_BYTES    = XFER_SIZE_WIDTH'(BYTES_PER_BEAT);
    // BYTES_PER_BEAT is a power of two, so this clears the sub-beat bits.
    localparam logic [XFER_SIZE_WIDTH-1:0] BEAT_MASK     = ~(BEAT_BYTES - XFER_SIZE_WIDTH'(1));

    ctrl_state_t                state_q;
    logic                       ap_idle_q;
    logic                       ap_ready_q;
    logic                       ap_done_q;
    logic [NUM_ENGINES-1:0]     eng_start_q;
    logic [XFER_SIZE_WIDTH-1:0] xfer_bytes_q;
    logic [XFER_SIZE_WIDTH-1:0] xfer_bytes_d;
    logic [XFER_SIZE_WIDTH-1:0] xfer_aligned;
    logic                       timeout_err_q;
    logic [CNT_WIDTH-1:0]       run_cycles_q;

    logic                       accept;
    logic                       in_run;
    logic                       all_done;
    logic [CNT_WIDTH-1:0]       cnt_inc;
    logic                       timeout_hit;

    // ---------------- size sanitiser ----------------
    assign xfer_aligned = scalar00 & BEAT_MASK;

    always_comb begin
        xfer_bytes_d = xfer_aligned;
        if (scalar00 == '0) begin
            xfer_bytes_d = DEFAULT_BYTES;
        end else if (xfer_aligned == '0) begin
            // Sub-beat request rounds up to a single beat rather than zero.
            xfer_bytes_d = BEAT_BYTES;
        end
    end

    // ---------------- done collection / counter ----------------
    assign accept = (state_q == S_IDLE) && ap_start;
    assign in_run = (state_q == S_RUN);

    vadd_done_collector #(
        .NUM_ENGINES (NUM_ENGINES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_done_collector (
        .clk_i      (ap_clk),
        .rst_i      (areset),
        .clear_i    (accept),
        .run_i      (in_run),
        .eng_done_i (eng_done),
        .all_done_o (all_done),
        .cnt_inc_o  (cnt_inc)
    );

    assign timeout_hit = (timeout_cycles != '0) && (cnt_inc == timeout_cycles);

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            ap_idle_q     <= 1'b1;
            ap_ready_q    <= 1'b0;
            ap_done_q     <= 1'b0;
            eng_start_q   <= '0;
            xfer_bytes_q  <= DEFAULT_BYTES;
            timeout_err_q <= 1'b0;
            run_cycles_q  <= '0;
        end else begin
            ap_ready_q  <= 1'b0;
            eng_start_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q       <= S_LAUNCH;
                        ap_idle_q     <= 1'b0;
                        ap_ready_q    <= 1'b1;
                        eng_start_q   <= '1;
                        xfer_bytes_q  <= xfer_bytes_d;
                        timeout_err_q <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // Completion is checked first so it wins a tie with the watchdog.
                    if (all_done) begin
                        state_q      <= S_DONE;
                        ap_done_q    <= 1'b1;
                        run_cycles_q <= cnt_inc;
                    end else if (timeout_hit) begin
                        state_q       <= S_DONE;
                        ap_done_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        run_cycles_q  <= cnt_inc;
                    end
                end
                S_DONE: begin
                    if (ap_continue) begin
                        state_q   <= S_IDLE;
                        ap_done_q <= 1'b0;
                        ap_idle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                end
            endcase
        end
    end

    assign ap_idle        = ap_idle_q;
    assign ap_ready       = ap_ready_q;
    assign ap_done        = ap_done_q;
    assign eng_start      = eng_start_q;
    assign eng_xfer_bytes = xfer_bytes_q;
    assign timeout_err    = timeout_err_q;
    assign run_cycles     = run_cycles_q;

endmodule : vadd_kernel_ctrl_seq

// File: tb/tb_vadd_kernel_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_vadd_kernel_ctrl_seq
// Directed bench for the vadd kernel control sequencer. Cycle numbers k are
// counted from the LAUNCH cycle (k=0, where ap_ready is seen).
// ---------------------------------------------------------------------------
module tb_vadd_kernel_ctrl_seq;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [31:0] scalar00;
    logic [31:0] timeout_cycles;
    logic [1:0]  eng_start;
    logic [31:0] eng_xfer_bytes;
    logic [1:0]  eng_done;
    logic        timeout_err;
    logic [31:0] run_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    int start_pulses = 0;
    int start_full   = 0;
    int ready_pulses = 0;
    int both_high    = 0;

    always #5 ap_clk = ~ap_clk;

    vadd_kernel_ctrl_seq dut (
        .ap_clk         (ap_clk),
        .areset         (areset),
        .ap_start       (ap_start),
        .ap_continue    (ap_continue),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .scalar00       (scalar00),
        .timeout_cycles (timeout_cycles),
        .eng_start      (eng_start),
        .eng_xfer_bytes (eng_xfer_bytes),
        .eng_done       (eng_done),
        .timeout_err    (timeout_err),
        .run_cycles     (run_cycles)
    );

    // Pulse monitors, sampled on the falling edge.
    always @(negedge ap_clk) begin
        if (eng_start != 2'b00) start_pulses++;
        if (eng_start == 2'b11) start_full++;
        if (ap_ready) ready_pulses++;
        if (ap_done && ap_idle) both_high++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_mon();
        start_pulses = 0;
        start_full   = 0;
        ready_pulses = 0;
    endtask

    // Raise ap_start and wait (bounded) for the LAUNCH cycle.
    task automatic launch(input logic [31:0] size, input logic hold_start);
        bit found = 0;
        scalar00 = size;
        ap_start = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (ap_ready) found = 1;
        end
        check("launch_seen", 64'(found), 64'd1);
        if (!hold_start) ap_start = 1'b0;
    endtask

    // Drive done pulses at cycles d0/d1 after LAUNCH (-1 = never) and
    // return the first cycle at which ap_done is seen.
    task automatic run_engines(input int d0, input int d1, input int maxk, output int done_at);
        done_at = -1;
        for (int k = 1; k <= maxk && done_at < 0; k++) begin
            tick();
            if (ap_done) begin
                done_at = k;
            end else begin
                eng_done[0] = (k == d0);
                eng_done[1] = (k == d1);
            end
        end
        eng_done = 2'b00;
        $display("run: size=%0d d0=%0d d1=%0d done_at=%0d run_cycles=%0d timeout_err=%0d",
                 eng_xfer_bytes, d0, d1, done_at, run_cycles, timeout_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int da;
        bit ok_done;
        bit ok_idle;
        logic [31:0] sizes [3];
        logic [31:0] exps  [3];
        sizes[0] = 32'd100;  exps[0] = 32'd64;
        sizes[1] = 32'd30;   exps[1] = 32'd64;
        sizes[2] = 32'd4096; exps[2] = 32'd4096;

        areset = 1'b1;
        ap_start = 1'b0;
        ap_continue = 1'b1;
        scalar00 = '0;
        timeout_cycles = '0;
        eng_done = 2'b00;
        tick();
        tick();
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_ready", 64'(ap_ready), 64'd0);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_start", 64'(eng_start), 64'd0);
        check("rst_xfer", 64'(eng_xfer_bytes), 64'd16384);
        check("rst_runcyc", 64'(run_cycles), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);
        areset = 1'b0;
        tick();

        // 1: default size, dones at 10 and 14
        clear_mon();
        launch(32'd0, 1'b0);
        check("t1_xfer", 64'(eng_xfer_bytes), 64'd16384);
        run_engines(10, 14, 40, da);
        check("t1_done_at", 64'(da), 64'd15);
        check("t1_runcyc", 64'(run_cycles), 64'd14);
        check("t1_terr", 64'(timeout_err), 64'd0);
        tick();
        check("t1_back_idle", 64'(ap_idle), 64'd1);
        check("t1_start_pulses", 64'(start_pulses), 64'd1);
        check("t1_start_full", 64'(start_full), 64'd1);
        check("t1_ready_pulses", 64'(ready_pulses), 64'd1);

        // 2: size sanitiser
        for (int i = 0; i < 3; i++) begin
            launch(sizes[i], 1'b0);
            check("t2_xfer", 64'(eng_xfer_bytes), 64'(exps[i]));
            run_engines(2, 2, 20, da);
            check("t2_done_at", 64'(da), 64'd3);
            tick();
        end

        // 3: same-cycle completion, stray dones in DONE and IDLE
        ap_continue = 1'b0;
        launch(32'd256, 1'b0);
        check("t3_xfer", 64'(eng_xfer_bytes), 64'd256);
        run_engines(7, 7, 20, da);
        check("t3_same_done_at", 64'(da), 64'd8);
        check("t3_same_runcyc", 64'(run_cycles), 64'd7);
        eng_done = 2'b10;
        tick();
        tick();
        eng_done = 2'b00;
        ap_continue = 1'b1;
        tick();
        tick();
        check("t3_idle", 64'(ap_idle), 64'd1);
        eng_done = 2'b01;
        tick();
        tick();
        eng_done = 2'b00;
        launch(32'd256, 1'b0);
        run_engines(9, 4, 30, da);
        check("t3_stray_done_at", 64'(da), 64'd10);
        check("t3_stray_runcyc", 64'(run_cycles), 64'd9);
        tick();

        // 4: watchdog
        timeout_cycles = 32'd50;
        launch(32'd64, 1'b0);
        run_engines(5, -1, 80, da);
        check("t4_done_at", 64'(da), 64'd51);
        check("t4_terr", 64'(timeout_err), 64'd1);
        check("t4_runcyc", 64'(run_cycles), 64'd50);
        tick();
        timeout_cycles = 32'd0;

        // 5: chain handshake
        ap_continue = 1'b0;
        launch(32'd128, 1'b0);
        check("t5_terr_cleared", 64'(timeout_err), 64'd0);
        run_engines(3, 3, 20, da);
        check("t5_done_at", 64'(da), 64'd4);
        clear_mon();
        ap_start = 1'b1;
        ok_done = 1;
        ok_idle = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ap_done) ok_done = 0;
            if (ap_idle) ok_idle = 0;
        end
        check("t5_done_held", 64'(ok_done), 64'd1);
        check("t5_not_idle", 64'(ok_idle), 64'd1);
        check("t5_no_relaunch", 64'(ready_pulses), 64'd0);
        ap_continue = 1'b1;
        tick();
        check("t5_idle_cycle", 64'(ap_idle), 64'd1);
        check("t5_done_low", 64'(ap_done), 64'd0);
        tick();
        check("t5_relaunch", 64'(ap_ready), 64'd1);
        ap_start = 1'b0;
        run_engines(2, 2, 20, da);
        check("t5_relaunch_done_at", 64'(da), 64'd3);
        tick();

        // 6: asynchronous reset mid-run
        launch(32'd512, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        areset = 1'b1;
        #2;
        check("t6_idle", 64'(ap_idle), 64'd1);
        check("t6_done", 64'(ap_done), 64'd0);
        check("t6_start", 64'(eng_start), 64'd0);
        check("t6_runcyc", 64'(run_cycles), 64'd0);
        check("t6_xfer", 64'(eng_xfer_bytes), 64'd16384);
        tick();
        tick();
        areset = 1'b0;
        tick();
        clear_mon();
        launch(32'd0, 1'b0);
        run_engines(10, 14, 40, da);
        check("t6_done_at", 64'(da), 64'd15);
        check("t6_runcyc", 64'(run_cycles), 64'd14);
        check("t6_start_pulses", 64'(start_pulses), 64'd1);
        tick();

        check("never_done_and_idle", 64'(both_high), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vadd_kernel_ctrl_seq
